// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one read in flight and buffers the returned instruction.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect raises o_misalign and parks the block in ERR until reset.
module ifu_fetch_ctrl #(
    parameter int            AW       = 64,
    parameter int            IW       = 32,
    parameter logic [AW-1:0] PC_START = AW'(64'h8000_0000)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_redir_valid,
    input  logic [AW-1:0] i_redir_pc,
    input  logic          i_stall,
    output logic          o_req_valid,
    input  logic          i_req_ready,
    output logic [AW-1:0] o_req_addr,
    input  logic          i_rsp_valid,
    input  logic [IW-1:0] i_rsp_data,
    output logic          o_rsp_ready,
    output logic          o_inst_valid,
    output logic [IW-1:0] o_inst,
    output logic [AW-1:0] o_inst_pc,
    output logic          o_busy,
    output logic          o_misalign
);

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
`ifdef FETCH_MISALIGN_CHK_EN
        , ST_ERR
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic          stale_q, stale_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [AW-1:0] inst_pc_q, inst_pc_d;
    logic [AW-1:0] redir_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    logic misalign_now;

    assign redir_pc     = i_redir_pc;
    assign misalign_now = i_redir_valid && (i_redir_pc[1:0] != 2'b00);
    assign misalign_d   = misalign_q | misalign_now;
    assign o_misalign   = misalign_q;
`else
    assign redir_pc   = i_redir_pc & ~{{(AW-2){1'b0}}, 2'b11};
    assign o_misalign = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        stale_d    = stale_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;

        if (i_redir_valid) fetch_pc_d = redir_pc;

        case (state_q)
            ST_REQ: begin
                // The pending address must still complete; remember that its data is unwanted.
                if (i_redir_valid) stale_d = 1'b1;
                if (i_req_ready) state_d = (stale_q || i_redir_valid) ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (i_rsp_valid) begin
                    if (i_redir_valid) begin
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = i_rsp_data;
                        inst_pc_d = req_addr_q;
                        state_d   = ST_HOLD;
                    end
                end else if (i_redir_valid) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (i_rsp_valid) state_d = ST_REQ;
            end
            ST_HOLD: begin
                if (i_redir_valid) begin
                    state_d = ST_REQ;
                end else if (!i_stall) begin
                    fetch_pc_d = inst_pc_q + AW'(4);
                    state_d    = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            ST_ERR: ;
`endif
            default: state_d = ST_REQ;
        endcase

`ifdef FETCH_MISALIGN_CHK_EN
        // Once the bus is quiet, a pending misalignment diverts the return to REQ into ERR.
        if (misalign_d && (state_d == ST_REQ) && (state_q != ST_REQ)) state_d = ST_ERR;
`endif

        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            req_addr_d = fetch_pc_d;
            stale_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    // i_rst_n is active-high despite its name.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= PC_START;
            req_addr_q <= PC_START;
            stale_q    <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= PC_START;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            stale_q    <= stale_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign o_req_valid  = (state_q == ST_REQ);
    assign o_req_addr   = req_addr_q;
    assign o_rsp_ready  = (state_q == ST_WAIT) || (state_q == ST_DROP);
    assign o_busy       = o_rsp_ready;
    assign o_inst_valid = (state_q == ST_HOLD) && !i_redir_valid;
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl; the bench drives the read port by hand, one cycle at a time.
module tb_ifu_fetch_ctrl;

    localparam int          AW  = 64;
    localparam int          IW  = 32;
    localparam logic [63:0] PC0 = 64'h8000_0000;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_redir_valid;
    logic [AW-1:0] i_redir_pc;
    logic          i_stall;
    logic          o_req_valid;
    logic          i_req_ready;
    logic [AW-1:0] o_req_addr;
    logic          i_rsp_valid;
    logic [IW-1:0] i_rsp_data;
    logic          o_rsp_ready;
    logic          o_inst_valid;
    logic [IW-1:0] o_inst;
    logic [AW-1:0] o_inst_pc;
    logic          o_busy;
    logic          o_misalign;

    int checks   = 0;
    int failures = 0;

    ifu_fetch_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_redir_valid(i_redir_valid),
        .i_redir_pc   (i_redir_pc),
        .i_stall      (i_stall),
        .o_req_valid  (o_req_valid),
        .i_req_ready  (i_req_ready),
        .o_req_addr   (o_req_addr),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_data   (i_rsp_data),
        .o_rsp_ready  (o_rsp_ready),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_busy       (o_busy),
        .o_misalign   (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    // Advance one cycle; inputs are driven and outputs sampled 2 ns after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b1;
        tick();
        tick();
        i_rst_n = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL reset_req_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== PC0) begin failures++; $display("FAIL reset_req_addr got=%h exp=%h", o_req_addr, PC0); end
        checks++; if (o_rsp_ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready got=%0b exp=0", o_rsp_ready); end
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%0b exp=0", o_inst_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
        checks++; if (o_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%0b exp=0", o_misalign); end
        checks++; if (o_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", o_inst); end
        checks++; if (o_inst_pc !== PC0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=%h", o_inst_pc, PC0); end
    endtask

    task automatic test_ready_low();
        i_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL ready_low_valid[%0d] got=%0b exp=1", i, o_req_valid); end
            checks++; if (o_req_addr !== PC0) begin failures++; $display("FAIL ready_low_addr[%0d] got=%h exp=%h", i, o_req_addr, PC0); end
        end
    endtask

    task automatic test_basic_fetch();
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", o_busy); end
        checks++; if (o_rsp_ready !== 1'b1) begin failures++; $display("FAIL basic_rsp_ready got=%0b exp=1", o_rsp_ready); end
        checks++; if (o_req_valid !== 1'b0) begin failures++; $display("FAIL basic_req_valid_wait got=%0b exp=0", o_req_valid); end
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0000_0013;
        tick();
        i_rsp_valid = 1'b0;
        #1;
        checks++; if (o_inst_valid !== 1'b1) begin failures++; $display("FAIL basic_inst_valid got=%0b exp=1", o_inst_valid); end
        checks++; if (o_inst !== 32'h0000_0013) begin failures++; $display("FAIL basic_inst got=%h exp=00000013", o_inst); end
        checks++; if (o_inst_pc !== PC0) begin failures++; $display("FAIL basic_inst_pc got=%h exp=%h", o_inst_pc, PC0); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_hold got=%0b exp=0", o_busy); end
        tick();
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL basic_next_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== 64'h8000_0004) begin failures++; $display("FAIL basic_next_addr got=%h exp=80000004", o_req_addr); end
    endtask

    task automatic test_redirect_wait();
        i_req_ready = 1'b1;
        tick();
        i_req_ready   = 1'b0;
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_1000;
        tick();
        i_redir_valid = 1'b0;
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL redir_wait_drop_busy got=%0b exp=1", o_busy); end
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'hdead_beef;
        #1;
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL redir_wait_inst_valid got=%0b exp=0", o_inst_valid); end
        tick();
        i_rsp_valid = 1'b0;
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL redir_wait_req_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== 64'h8000_1000) begin failures++; $display("FAIL redir_wait_addr got=%h exp=80001000", o_req_addr); end
        checks++; if (o_inst !== 32'h0000_0013) begin failures++; $display("FAIL redir_wait_buffer got=%h exp=00000013", o_inst); end
    endtask

    task automatic test_redirect_with_rsp();
        i_req_ready = 1'b1;
        tick();
        i_req_ready   = 1'b0;
        i_rsp_valid   = 1'b1;
        i_rsp_data    = 32'h1111_2222;
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_1100;
        #1;
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL redir_rsp_inst_valid got=%0b exp=0", o_inst_valid); end
        tick();
        i_rsp_valid   = 1'b0;
        i_redir_valid = 1'b0;
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL redir_rsp_req_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== 64'h8000_1100) begin failures++; $display("FAIL redir_rsp_addr got=%h exp=80001100", o_req_addr); end
        checks++; if (o_inst !== 32'h0000_0013) begin failures++; $display("FAIL redir_rsp_buffer got=%h exp=00000013", o_inst); end
    endtask

    task automatic test_redirect_req();
        i_req_ready   = 1'b0;
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_2000;
        tick();
        i_redir_valid = 1'b0;
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL redir_req_valid_held got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== 64'h8000_1100) begin failures++; $display("FAIL redir_req_addr_held got=%h exp=80001100", o_req_addr); end
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL redir_req_drop_busy got=%0b exp=1", o_busy); end
        checks++; if (o_req_valid !== 1'b0) begin failures++; $display("FAIL redir_req_drop_valid got=%0b exp=0", o_req_valid); end
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0bad_0bad;
        #1;
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL redir_req_inst_valid got=%0b exp=0", o_inst_valid); end
        tick();
        i_rsp_valid = 1'b0;
        checks++; if (o_req_addr !== 64'h8000_2000) begin failures++; $display("FAIL redir_req_new_addr got=%h exp=80002000", o_req_addr); end
        checks++; if (o_inst !== 32'h0000_0013) begin failures++; $display("FAIL redir_req_buffer got=%h exp=00000013", o_inst); end
    endtask

    task automatic test_hold_stall();
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h00a0_0093;
        tick();
        i_rsp_valid = 1'b0;
        i_stall     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (o_inst_valid !== 1'b1) begin failures++; $display("FAIL stall_inst_valid[%0d] got=%0b exp=1", i, o_inst_valid); end
            checks++; if (o_inst !== 32'h00a0_0093) begin failures++; $display("FAIL stall_inst[%0d] got=%h exp=00a00093", i, o_inst); end
            checks++; if (o_inst_pc !== 64'h8000_2000) begin failures++; $display("FAIL stall_inst_pc[%0d] got=%h exp=80002000", i, o_inst_pc); end
            tick();
        end
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_3000;
        #1;
        checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL stall_squash got=%0b exp=0", o_inst_valid); end
        tick();
        i_redir_valid = 1'b0;
        i_stall       = 1'b0;
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL stall_next_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== 64'h8000_3000) begin failures++; $display("FAIL stall_next_addr got=%h exp=80003000", o_req_addr); end
    endtask

    task automatic test_pc_wrap();
        i_req_ready   = 1'b0;
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        i_redir_valid = 1'b0;
        i_req_ready   = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0;
        tick();
        i_rsp_valid = 1'b0;
        checks++; if (o_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_top_addr got=%h exp=fffffffffffffffc", o_req_addr); end
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0000_0073;
        tick();
        i_rsp_valid = 1'b0;
        checks++; if (o_inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_inst_pc got=%h exp=fffffffffffffffc", o_inst_pc); end
        tick();
        checks++; if (o_req_addr !== 64'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=0", o_req_addr); end
    endtask

    task automatic test_misalign();
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_data  = 32'h0000_0013;
        tick();
        i_rsp_valid   = 1'b0;
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_4003;
        tick();
        i_redir_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        i_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (o_misalign !== 1'b1) begin failures++; $display("FAIL misalign_flag[%0d] got=%0b exp=1", i, o_misalign); end
            checks++; if (o_req_valid !== 1'b0) begin failures++; $display("FAIL misalign_req_valid[%0d] got=%0b exp=0", i, o_req_valid); end
            checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL misalign_inst_valid[%0d] got=%0b exp=0", i, o_inst_valid); end
            tick();
        end
        i_req_ready = 1'b0;
`else
        checks++; if (o_misalign !== 1'b0) begin failures++; $display("FAIL misalign_flag got=%0b exp=0", o_misalign); end
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL misalign_req_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== 64'h8000_4000) begin failures++; $display("FAIL misalign_cleared_addr got=%h exp=80004000", o_req_addr); end
`endif
    endtask

    task automatic test_reset_mid();
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_rst_n     = 1'b1;
        tick();
        i_rst_n = 1'b0;
        checks++; if (o_req_valid !== 1'b1) begin failures++; $display("FAIL midrst_req_valid got=%0b exp=1", o_req_valid); end
        checks++; if (o_req_addr !== PC0) begin failures++; $display("FAIL midrst_req_addr got=%h exp=%h", o_req_addr, PC0); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", o_busy); end
        checks++; if (o_misalign !== 1'b0) begin failures++; $display("FAIL midrst_misalign got=%0b exp=0", o_misalign); end
    endtask

    initial begin
        i_rst_n       = 1'b1;
        i_redir_valid = 1'b0;
        i_redir_pc    = '0;
        i_stall       = 1'b0;
        i_req_ready   = 1'b0;
        i_rsp_valid   = 1'b0;
        i_rsp_data    = '0;

        test_reset();
        test_ready_low();
        test_basic_fetch();
        test_redirect_wait();
        test_redirect_with_rsp();
        test_redirect_req();
        test_hold_stall();
        test_pc_wrap();
        test_misalign();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch sequencer between the PC/branch unit and the instruction-side AXI-style read port. It owns the fetch PC, issues one outstanding read at a time, buffers the returned instruction for the IF/ID stage, and applies redirects from branch/jump resolution or trap entry/return. In-flight fetches made stale by a redirect are discarded without breaking bus handshake rules.

## Interface
Parameters:
- `PC_START`, `64'h8000_0000`, fetch PC after reset.
- `AW`, `64`, address/PC width.
- `IW`, `32`, instruction width.

Ports:
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst_n`  in  1  reset, synchronous and active-high (1 = reset); name kept per codebase.
- `i_redir_valid`  in  1  redirect request; single-cycle pulse from branch/trap logic.
- `i_redir_pc`  in  AW  redirect target.
- `i_stall`  in  1  IF/ID cannot accept this cycle.
- `o_req_valid`  out  1  read-address valid.
- `i_req_ready`  in  1  read-address ready.
- `o_req_addr`  out  AW  read address; held stable while `o_req_valid` is high.
- `i_rsp_valid`  in  1  read-data valid.
- `i_rsp_data`  in  IW  read data.
- `o_rsp_ready`  out  1  read-data ready.
- `o_inst_valid`  out  1  instruction presented to IF/ID.
- `o_inst`  out  IW  instruction.
- `o_inst_pc`  out  AW  PC of `o_inst`.
- `o_busy`  out  1  a read is outstanding (state WAIT or DROP).
- `o_misalign`  out  1  sticky misaligned-redirect flag; tied 0 without `FETCH_MISALIGN_CHK_EN`.

## Operation
- Registers: `fetch_pc` (next address), `req_addr` (address on bus), `stale` flag, instruction buffer {`o_inst`, `o_inst_pc`}.
- States: REQ, WAIT, HOLD, DROP, plus ERR (macro only).
- REQ: `o_req_valid`=1, `o_req_addr`=`req_addr`. On `o_req_valid & i_req_ready`: go to WAIT, or to DROP if `stale` or `i_redir_valid`.
- WAIT: `o_rsp_ready`=1. On `i_rsp_valid`:
  - no redirect this cycle: capture data and `req_addr` into the buffer, go to HOLD;
  - redirect this cycle: discard the data, go to REQ.
  - A redirect in WAIT without a response goes to DROP.
- DROP: `o_rsp_ready`=1. On `i_rsp_valid`, discard the data and go to REQ.
- HOLD: `o_inst_valid = ~i_redir_valid`. When `~i_stall & ~i_redir_valid`, set `fetch_pc = o_inst_pc + 4` and go to REQ. A redirect squashes the buffered instruction and goes to REQ.
- Any redirect in any state sets `fetch_pc = i_redir_pc`. Redirect has priority over the sequential PC.
- `req_addr` loads from `fetch_pc` (or `i_redir_pc` if redirecting that cycle) on every entry to REQ. It never changes while in REQ.
- Redirect in REQ without a handshake: `fetch_pc` updates and `stale` is set. The pending address completes, then DROP, then REQ at the new PC.
- `stale` clears on entry to REQ from DROP/WAIT/HOLD.
- PC arithmetic is modulo 2^AW; `+4` wraps silently.

## Timing
- Reset values: state REQ, `fetch_pc`=`req_addr`=`PC_START`, `o_req_valid`=1 in the first cycle after reset. `o_rsp_ready`, `o_inst_valid`, `o_busy`, `o_misalign`, `stale` are 0. `o_inst`=0, `o_inst_pc`=`PC_START`.
- Reset mid-operation forces REQ regardless of outstanding reads. The memory side is reset on the same `i_rst_n`.
- Latency: handshake at cycle t, response at t+k, `o_inst_valid` at t+k+1. Next request is no earlier than the cycle after consumption.
- Best-case throughput is one instruction per 3 cycles with zero-wait memory.
- All outputs are registered except `o_inst_valid`, which is gated by `i_redir_valid`.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined: a redirect with `i_redir_pc[1:0]`≠0 sets `o_misalign`=1.
  - In REQ, WAIT or DROP, the block finishes any outstanding read, discards it, then enters ERR; from HOLD it enters ERR directly.
  - ERR issues no requests and keeps `o_inst_valid`=0 until reset.
- Undefined: `i_redir_pc[1:0]` is cleared on load, `o_misalign` is constant 0, and no ERR state exists.

## Test plan
- Reset release, memory returns `32'h00000013` 1 cycle after handshake, `i_stall`=0 → first `o_req_addr`=`0x80000000`, `o_inst_valid` with `o_inst_pc`=`0x80000000`, next request at `0x80000004`.
- `i_req_ready` low for 3 cycles → `o_req_addr` stays `0x80000000` and `o_req_valid` stays 1 every cycle.
- Redirect to `0x80001000` while in WAIT → next response discarded (`o_inst_valid` stays 0), next request at `0x80001000`.
- Redirect to `0x80002000` in REQ with `i_req_ready`=0 → old address completes, enters DROP, its response is dropped, then request at `0x80002000`.
- HOLD with `i_stall`=1 for 4 cycles, then redirect → `o_inst` held 4 cycles, squashed on the redirect cycle, next request at the redirect target.
- Macro on, redirect to `0x80000002` → `o_misalign`=1, no further `o_req_valid` until reset.
